// File: rtl/dac_playback_buffer_pkg.sv
// Shared definitions for the DAC playback buffer: FSM state encoding,
// register word offsets and CTRL bit positions.
package dac_playback_buffer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PRIME = 2'd1,
    ST_RUN   = 2'd2
  } state_t;

  localparam logic [11:0] REG_CTRL   = 12'h000;
  localparam logic [11:0] REG_LEN    = 12'h004;
  localparam logic [11:0] REG_DIV    = 12'h008;
  localparam logic [11:0] REG_STATUS = 12'h00C;

  localparam int RAM_SEL_BIT = 12;

  localparam int CTRL_START = 0;
  localparam int CTRL_LOOP  = 1;
  localparam int CTRL_STOP  = 2;
  localparam int CTRL_ARM   = 3;

endpackage

// File: rtl/dac_playback_buffer_if.sv
// System bus seen by the DAC playback buffer. The host drives address, data
// and the single-cycle strobes; the buffer answers with read data, ack and err.
interface dac_playback_buffer_if;

  logic [31:0] sys_addr;
  logic [31:0] sys_wdata;
  logic        sys_wen;
  logic        sys_ren;
  logic [31:0] sys_rdata;
  logic        sys_ack;
  logic        sys_err;

  modport master (
    output sys_addr, sys_wdata, sys_wen, sys_ren,
    input  sys_rdata, sys_ack, sys_err
  );

  modport slave (
    input  sys_addr, sys_wdata, sys_wen, sys_ren,
    output sys_rdata, sys_ack, sys_err
  );

endinterface

// File: rtl/dac_playback_buffer_ram.sv
// Sample RAM for the playback buffer: simple dual-port, bus-side write port,
// playback-side registered read port with one cycle of latency. A read and
// write to the same address in the same cycle returns the old word.
module dac_playback_ram #(
  parameter int ADDR_BITS = 10
) (
  input  logic                 clk,
  input  logic                 i_we,
  input  logic [ADDR_BITS-1:0] i_waddr,
  input  logic [31:0]          i_wdata,
  input  logic [ADDR_BITS-1:0] i_raddr,
  output logic [31:0]          o_rdata
);

  logic [31:0] r_mem [2**ADDR_BITS];

  // Memory array and read register; non-blocking ordering gives read-first behaviour
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
    o_rdata <= r_mem[i_raddr];
  end

endmodule

// File: rtl/dac_playback_buffer.sv
// DAC playback buffer top: host-loaded {ch1,ch0} sample RAM streamed to two
// DAC channels at a programmable rate, one-shot or looped.
// Optional feature macro: DAC_PLAYBACK_EXT_TRIG_EN adds trig_in and CTRL[3] arm.
module dac_playback_buffer
  import dac_playback_buffer_pkg::*;
#(
  parameter int ADDR_BITS = 10,
  parameter int DIV_BITS  = 16
) (
  input  logic                clk,
  input  logic                rst,
`ifdef DAC_PLAYBACK_EXT_TRIG_EN
  input  logic                trig_in,
`endif
  dac_playback_buffer_if.slave bus,
  output logic signed [15:0]  dac_out0,
  output logic signed [15:0]  dac_out1,
  output logic                busy,
  output logic                done_pulse
);

  state_t               r_state;
  logic                 r_busy, r_done, r_loop, r_endPending, r_ack;
  logic [ADDR_BITS-1:0] r_len, r_lenAct, r_idx;
  logic [DIV_BITS-1:0]  r_div, r_divAct, r_hold;
  logic [15:0]          r_dac0, r_dac1;
  logic [31:0]          r_rdata;
  logic [31:0]          w_rdMux, w_rdData;
  logic [ADDR_BITS-1:0] w_rdAddr;
  logic [11:0]          w_off;
  logic                 w_regSel, w_ctrlWr, w_lenWr, w_divWr, w_ramWe;
  logic                 w_startCmd, w_stopCmd, w_trigStart, w_armBit, w_go;
  logic                 w_holdDone, w_lastIdx, w_unused;

  assign w_regSel   = ~bus.sys_addr[RAM_SEL_BIT];
  assign w_off      = bus.sys_addr[11:0];
  assign w_ctrlWr   = bus.sys_wen & w_regSel & (w_off == REG_CTRL);
  assign w_lenWr    = bus.sys_wen & w_regSel & (w_off == REG_LEN);
  assign w_divWr    = bus.sys_wen & w_regSel & (w_off == REG_DIV);
  assign w_ramWe    = bus.sys_wen & ~w_regSel;
  assign w_stopCmd  = w_ctrlWr & bus.sys_wdata[CTRL_STOP];
  assign w_startCmd = w_ctrlWr & bus.sys_wdata[CTRL_START] & ~bus.sys_wdata[CTRL_STOP];
  assign w_go       = w_startCmd | w_trigStart;
  assign w_holdDone = (r_hold == r_divAct);
  assign w_lastIdx  = (r_idx == r_lenAct);
  assign w_unused   = ^{bus.sys_addr[31:13], bus.sys_addr[1:0], bus.sys_wdata};

`ifdef DAC_PLAYBACK_EXT_TRIG_EN
  logic r_arm, r_trigPrev, r_trigEdge;

  // Registered rising-edge detect on trig_in and the one-shot arm flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_arm      <= 1'b0;
      r_trigPrev <= 1'b0;
      r_trigEdge <= 1'b0;
    end else begin
      r_trigPrev <= trig_in;
      r_trigEdge <= trig_in & ~r_trigPrev;
      if (w_ctrlWr) begin
        r_arm <= bus.sys_wdata[CTRL_ARM];
      end else if (w_trigStart) begin
        r_arm <= 1'b0;
      end
    end
  end

  assign w_trigStart = r_trigEdge & r_arm & (r_state == ST_IDLE);
  assign w_armBit    = r_arm;
`else
  assign w_trigStart = 1'b0;
  assign w_armBit    = 1'b0;
`endif

  // Host-programmed configuration registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_len  <= '1;
      r_div  <= '0;
      r_loop <= 1'b0;
    end else begin
      if (w_lenWr) r_len <= bus.sys_wdata[ADDR_BITS-1:0];
      if (w_divWr) r_div <= bus.sys_wdata[DIV_BITS-1:0];
      if (w_ctrlWr) r_loop <= bus.sys_wdata[CTRL_LOOP];
    end
  end

  // Register read multiplexer; RAM region and unmapped offsets read as zero
  always_comb begin
    w_rdMux = '0;
    if (w_regSel) begin
      case (w_off)
        REG_CTRL: begin
          w_rdMux[CTRL_LOOP] = r_loop;
          w_rdMux[CTRL_ARM]  = w_armBit;
        end
        REG_LEN:    w_rdMux[ADDR_BITS-1:0] = r_len;
        REG_DIV:    w_rdMux[DIV_BITS-1:0]  = r_div;
        REG_STATUS: begin
          w_rdMux[0]                = r_busy;
          w_rdMux[1]                = r_loop;
          w_rdMux[ADDR_BITS+15:16]  = r_idx;
        end
        default: ;
      endcase
    end
  end

  // Read data and ack arrive the cycle after the read strobe
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ack   <= 1'b0;
      r_rdata <= '0;
    end else begin
      r_ack   <= bus.sys_ren;
      r_rdata <= bus.sys_ren ? w_rdMux : '0;
    end
  end

  assign bus.sys_ack   = r_ack | bus.sys_wen;
  assign bus.sys_rdata = r_rdata;
  assign bus.sys_err   = 1'b0;

  // Prefetch the next index on the last hold cycle so the output never stalls
  always_comb begin
    w_rdAddr = r_idx;
    if ((r_state == ST_RUN) && w_holdDone) begin
      w_rdAddr = w_lastIdx ? '0 : r_idx + 1'b1;
    end
  end

  dac_playback_ram #(.ADDR_BITS(ADDR_BITS)) u_ram (
    .clk     (clk),
    .i_we    (w_ramWe),
    .i_waddr (bus.sys_addr[ADDR_BITS+1:2]),
    .i_wdata (bus.sys_wdata),
    .i_raddr (w_rdAddr),
    .o_rdata (w_rdData)
  );

  // Playback FSM with registered DAC, busy and done outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_idx        <= '0;
      r_hold       <= '0;
      r_lenAct     <= '1;
      r_divAct     <= '0;
      r_endPending <= 1'b0;
      r_dac0       <= '0;
      r_dac1       <= '0;
    end else begin
      r_done <= 1'b0;
      if (w_stopCmd) begin
        r_state      <= ST_IDLE;
        r_busy       <= 1'b0;
        r_done       <= r_busy;
        r_endPending <= 1'b0;
        r_dac0       <= '0;
        r_dac1       <= '0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (w_go) begin
              r_state      <= ST_PRIME;
              r_busy       <= 1'b1;
              r_idx        <= '0;
              r_hold       <= '0;
              r_lenAct     <= r_len;
              r_divAct     <= r_div;
              r_endPending <= 1'b0;
            end
          end
          ST_PRIME: r_state <= ST_RUN;
          ST_RUN: begin
            if (r_endPending) begin
              r_state      <= ST_IDLE;
              r_busy       <= 1'b0;
              r_done       <= 1'b1;
              r_endPending <= 1'b0;
              r_dac0       <= '0;
              r_dac1       <= '0;
            end else begin
              if (r_hold == '0) begin
                r_dac0 <= w_rdData[15:0];
                r_dac1 <= w_rdData[31:16];
              end
              if (w_holdDone) begin
                r_hold   <= '0;
                r_lenAct <= r_len;
                r_divAct <= r_div;
                if (!w_lastIdx) begin
                  r_idx <= r_idx + 1'b1;
                end else if (r_loop) begin
                  r_idx <= '0;
                end else begin
                  r_endPending <= 1'b1;
                end
              end else begin
                r_hold <= r_hold + 1'b1;
              end
            end
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign dac_out0   = r_dac0;
  assign dac_out1   = r_dac1;
  assign busy       = r_busy;
  assign done_pulse = r_done;

endmodule

// File: tb/tb_dac_playback_buffer.sv
// Self-checking bench for dac_playback_buffer. Expected DAC streams come from
// a sample-list model: each RAM word repeated DIV+1 times, per pass.
// Trigger scenario is compiled only with DAC_PLAYBACK_EXT_TRIG_EN.
module tb_dac_playback_buffer;

  localparam logic [31:0] A_CTRL   = 32'h0000_0000;
  localparam logic [31:0] A_LEN    = 32'h0000_0004;
  localparam logic [31:0] A_DIV    = 32'h0000_0008;
  localparam logic [31:0] A_STATUS = 32'h0000_000C;

  logic               clk = 1'b0;
  logic               rst;
  logic signed [15:0] dac_out0, dac_out1;
  logic               busy, done_pulse;
`ifdef DAC_PLAYBACK_EXT_TRIG_EN
  logic               trig_in;
`endif

  int passCount  = 0;
  int checkCount = 0;

  logic [31:0] tb_ram [$];
  logic [31:0] exp_q  [$];

  dac_playback_buffer_if bus_if ();

  dac_playback_buffer dut (
    .clk        (clk),
    .rst        (rst),
`ifdef DAC_PLAYBACK_EXT_TRIG_EN
    .trig_in    (trig_in),
`endif
    .bus        (bus_if),
    .dac_out0   (dac_out0),
    .dac_out1   (dac_out1),
    .busy       (busy),
    .done_pulse (done_pulse)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    bus_if.sys_addr  = a;
    bus_if.sys_wdata = d;
    bus_if.sys_wen   = 1'b1;
    step();
    bus_if.sys_wen   = 1'b0;
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d,
                          output logic ackEarly, output logic ack);
    bus_if.sys_addr = a;
    bus_if.sys_ren  = 1'b1;
    #1;
    ackEarly = bus_if.sys_ack;
    step();
    bus_if.sys_ren = 1'b0;
    ack = bus_if.sys_ack;
    d   = bus_if.sys_rdata;
  endtask

  task automatic load_ram(input int idx, input logic [31:0] d);
    tb_ram[idx] = d;
    bus_write(32'h0000_1000 + 32'(idx * 4), d);
  endtask

  task automatic load_counting();
    for (int i = 0; i < 4; i++) load_ram(i, {16'hA000 + 16'(i), 16'(i + 1)});
  endtask

  // Expected output list: every sample 0..len held div+1 cycles, repeated per pass
  task automatic model_play(input int len, input int div, input int passes);
    exp_q.delete();
    for (int p = 0; p < passes; p++)
      for (int i = 0; i <= len; i++)
        for (int h = 0; h <= div; h++)
          exp_q.push_back(tb_ram[i]);
  endtask

  task automatic test_reset();
    logic [31:0] d;
    logic        ae, ak;
    checkCount++;
    if (dac_out0 !== 16'd0 || dac_out1 !== 16'd0) $display("[TB] FAIL reset_dac got %h/%h exp 0/0", dac_out0, dac_out1);
    else passCount++;
    checkCount++;
    if (busy !== 1'b0 || done_pulse !== 1'b0) $display("[TB] FAIL reset_flags busy=%b done=%b exp 0/0", busy, done_pulse);
    else passCount++;
    checkCount++;
    if (bus_if.sys_ack !== 1'b0 || bus_if.sys_rdata !== 32'd0 || bus_if.sys_err !== 1'b0)
      $display("[TB] FAIL reset_bus ack=%b rdata=%h err=%b exp 0", bus_if.sys_ack, bus_if.sys_rdata, bus_if.sys_err);
    else passCount++;
    bus_read(A_LEN, d, ae, ak);
    checkCount++;
    if (ak !== 1'b1 || d !== 32'h0000_03FF) $display("[TB] FAIL reset_len ack=%b got %h exp 000003ff", ak, d);
    else passCount++;
    bus_read(A_DIV, d, ae, ak);
    checkCount++;
    if (d !== 32'd0) $display("[TB] FAIL reset_div got %h exp 0", d);
    else passCount++;
    bus_read(A_STATUS, d, ae, ak);
    checkCount++;
    if (d !== 32'd0) $display("[TB] FAIL reset_status got %h exp 0", d);
    else passCount++;
    bus_read(A_CTRL, d, ae, ak);
    checkCount++;
    if (d !== 32'd0) $display("[TB] FAIL reset_ctrl got %h exp 0", d);
    else passCount++;
  endtask

  task automatic test_bus();
    logic [31:0] d;
    logic        ae, ak;
    bus_if.sys_addr  = A_LEN;
    bus_if.sys_wdata = 32'h0000_0155;
    bus_if.sys_wen   = 1'b1;
    #1;
    checkCount++;
    if (bus_if.sys_ack !== 1'b1) $display("[TB] FAIL write_ack got %b exp 1", bus_if.sys_ack);
    else passCount++;
    step();
    bus_if.sys_wen = 1'b0;
    bus_read(A_LEN, d, ae, ak);
    checkCount++;
    if (ae !== 1'b0 || ak !== 1'b1) $display("[TB] FAIL read_ack_timing early=%b late=%b exp 0/1", ae, ak);
    else passCount++;
    checkCount++;
    if (d !== 32'h0000_0155) $display("[TB] FAIL read_len got %h exp 00000155", d);
    else passCount++;
    bus_read(32'h0000_0010, d, ae, ak);
    checkCount++;
    if (ak !== 1'b1 || d !== 32'd0) $display("[TB] FAIL read_unmapped ack=%b got %h exp 1/0", ak, d);
    else passCount++;
  endtask

  task automatic test_oneshot_basic();
    load_counting();
    bus_write(A_LEN, 32'd3);
    bus_write(A_DIV, 32'd0);
    bus_write(A_CTRL, 32'h1);
    step();
    checkCount++;
    if (dac_out0 !== 16'd0 || busy !== 1'b1) $display("[TB] FAIL basic_latency got out=%h busy=%b exp 0/1", dac_out0, busy);
    else passCount++;
    step();
    model_play(3, 0, 1);
    for (int k = 0; k < exp_q.size(); k++) begin
      checkCount++;
      if (dac_out0 !== exp_q[k][15:0] || dac_out1 !== exp_q[k][31:16] || done_pulse !== 1'b0)
        $display("[TB] FAIL basic_seq k=%0d got %h/%h done=%b exp %h/%h", k, dac_out1, dac_out0, done_pulse, exp_q[k][31:16], exp_q[k][15:0]);
      else passCount++;
      step();
    end
    checkCount++;
    if (dac_out0 !== 16'd0 || dac_out1 !== 16'd0 || done_pulse !== 1'b1 || busy !== 1'b0)
      $display("[TB] FAIL basic_end got %h/%h done=%b busy=%b exp 0/0/1/0", dac_out1, dac_out0, done_pulse, busy);
    else passCount++;
    step();
    checkCount++;
    if (done_pulse !== 1'b0) $display("[TB] FAIL basic_done_width got %b exp 0", done_pulse);
    else passCount++;
  endtask

  task automatic test_random_oneshot();
    for (int it = 0; it < 4; it++) begin
      int len = int'($urandom_range(0, 7));
      int div = int'($urandom_range(0, 3));
      for (int i = 0; i <= len; i++) load_ram(i, $urandom);
      bus_write(A_LEN, 32'(len));
      bus_write(A_DIV, 32'(div));
      bus_write(A_CTRL, 32'h1);
      step();
      step();
      model_play(len, div, 1);
      for (int k = 0; k < exp_q.size(); k++) begin
        checkCount++;
        if (dac_out0 !== exp_q[k][15:0] || dac_out1 !== exp_q[k][31:16] || busy !== 1'b1 || done_pulse !== 1'b0)
          $display("[TB] FAIL rand_seq it=%0d k=%0d got %h/%h busy=%b done=%b exp %h/%h", it, k, dac_out1, dac_out0, busy, done_pulse, exp_q[k][31:16], exp_q[k][15:0]);
        else passCount++;
        step();
      end
      checkCount++;
      if (dac_out0 !== 16'd0 || done_pulse !== 1'b1 || busy !== 1'b0)
        $display("[TB] FAIL rand_end it=%0d got %h done=%b busy=%b exp 0/1/0", it, dac_out0, done_pulse, busy);
      else passCount++;
      step();
    end
  endtask

  task automatic test_loop_stop();
    load_counting();
    bus_write(A_LEN, 32'd3);
    bus_write(A_DIV, 32'd2);
    bus_write(A_CTRL, 32'h3);
    step();
    step();
    model_play(3, 2, 2);
    for (int k = 0; k < exp_q.size(); k++) begin
      checkCount++;
      if (dac_out0 !== exp_q[k][15:0] || dac_out1 !== exp_q[k][31:16] || done_pulse !== 1'b0)
        $display("[TB] FAIL loop_seq k=%0d got %h/%h done=%b exp %h/%h", k, dac_out1, dac_out0, done_pulse, exp_q[k][31:16], exp_q[k][15:0]);
      else passCount++;
      step();
    end
    bus_write(A_CTRL, 32'h4);
    checkCount++;
    if (dac_out0 !== 16'd0 || dac_out1 !== 16'd0 || done_pulse !== 1'b1 || busy !== 1'b0)
      $display("[TB] FAIL loop_stop got %h/%h done=%b busy=%b exp 0/0/1/0", dac_out1, dac_out0, done_pulse, busy);
    else passCount++;
    step();
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i <= 5; i++) load_ram(i, $urandom);
    bus_write(A_LEN, 32'd5);
    bus_write(A_DIV, 32'd1);
    bus_write(A_CTRL, 32'h1);
    step();
    step();
    model_play(5, 1, 1);
    for (int k = 0; k < exp_q.size(); k++) begin
      if (k == 3) begin
        bus_if.sys_addr  = A_CTRL;
        bus_if.sys_wdata = 32'h1;
        bus_if.sys_wen   = 1'b1;
      end else begin
        bus_if.sys_wen = 1'b0;
      end
      checkCount++;
      if (dac_out0 !== exp_q[k][15:0] || dac_out1 !== exp_q[k][31:16] || busy !== 1'b1)
        $display("[TB] FAIL b2b_seq k=%0d got %h/%h busy=%b exp %h/%h", k, dac_out1, dac_out0, busy, exp_q[k][31:16], exp_q[k][15:0]);
      else passCount++;
      step();
    end
    checkCount++;
    if (dac_out0 !== 16'd0 || done_pulse !== 1'b1 || busy !== 1'b0)
      $display("[TB] FAIL b2b_end got %h done=%b busy=%b exp 0/1/0", dac_out0, done_pulse, busy);
    else passCount++;
    step();
  endtask

  task automatic test_loop_clear();
    load_counting();
    bus_write(A_LEN, 32'd3);
    bus_write(A_DIV, 32'd1);
    bus_write(A_CTRL, 32'h3);
    step();
    step();
    model_play(3, 1, 1);
    for (int k = 0; k < exp_q.size(); k++) begin
      if (k == 2) begin
        bus_if.sys_addr  = A_CTRL;
        bus_if.sys_wdata = 32'h0;
        bus_if.sys_wen   = 1'b1;
      end else begin
        bus_if.sys_wen = 1'b0;
      end
      checkCount++;
      if (dac_out0 !== exp_q[k][15:0] || done_pulse !== 1'b0)
        $display("[TB] FAIL loopclr_seq k=%0d got %h done=%b exp %h", k, dac_out0, done_pulse, exp_q[k][15:0]);
      else passCount++;
      step();
    end
    checkCount++;
    if (dac_out0 !== 16'd0 || done_pulse !== 1'b1 || busy !== 1'b0)
      $display("[TB] FAIL loopclr_end got %h done=%b busy=%b exp 0/1/0", dac_out0, done_pulse, busy);
    else passCount++;
    step();
  endtask

  task automatic test_start_stop_same();
    bus_write(A_CTRL, 32'h5);
    for (int k = 0; k < 5; k++) begin
      checkCount++;
      if (busy !== 1'b0 || dac_out0 !== 16'd0 || dac_out1 !== 16'd0 || done_pulse !== 1'b0)
        $display("[TB] FAIL startstop k=%0d busy=%b out=%h/%h done=%b exp all 0", k, busy, dac_out1, dac_out0, done_pulse);
      else passCount++;
      step();
    end
  endtask

  task automatic test_async_reset();
    logic [31:0] d;
    logic        ae, ak;
    load_counting();
    bus_write(A_LEN, 32'd3);
    bus_write(A_DIV, 32'd0);
    bus_write(A_CTRL, 32'h3);
    repeat (4) step();
    #2;
    rst = 1'b1;
    #1;
    checkCount++;
    if (dac_out0 !== 16'd0 || dac_out1 !== 16'd0 || busy !== 1'b0 || done_pulse !== 1'b0)
      $display("[TB] FAIL async_rst got %h/%h busy=%b done=%b exp 0/0/0/0", dac_out1, dac_out0, busy, done_pulse);
    else passCount++;
    @(posedge clk);
    #1;
    rst = 1'b0;
    step();
    bus_read(A_LEN, d, ae, ak);
    checkCount++;
    if (d !== 32'h0000_03FF) $display("[TB] FAIL async_len got %h exp 000003ff", d);
    else passCount++;
    bus_write(A_LEN, 32'd3);
    bus_write(A_CTRL, 32'h1);
    step();
    step();
    model_play(3, 0, 1);
    for (int k = 0; k < exp_q.size(); k++) begin
      checkCount++;
      if (dac_out0 !== exp_q[k][15:0] || dac_out1 !== exp_q[k][31:16])
        $display("[TB] FAIL replay_seq k=%0d got %h/%h exp %h/%h", k, dac_out1, dac_out0, exp_q[k][31:16], exp_q[k][15:0]);
      else passCount++;
      step();
    end
    checkCount++;
    if (dac_out0 !== 16'd0 || done_pulse !== 1'b1)
      $display("[TB] FAIL replay_end got %h done=%b exp 0/1", dac_out0, done_pulse);
    else passCount++;
    step();
  endtask

`ifdef DAC_PLAYBACK_EXT_TRIG_EN
  task automatic test_ext_trig();
    load_counting();
    bus_write(A_LEN, 32'd3);
    bus_write(A_DIV, 32'd0);
    bus_write(A_CTRL, 32'h8);
    step();
    trig_in = 1'b1;
    step();
    step();
    trig_in = 1'b0;
    step();
    checkCount++;
    if (dac_out0 !== 16'd0) $display("[TB] FAIL trig_early got %h exp 0", dac_out0);
    else passCount++;
    step();
    model_play(3, 0, 1);
    for (int k = 0; k < exp_q.size(); k++) begin
      checkCount++;
      if (dac_out0 !== exp_q[k][15:0])
        $display("[TB] FAIL trig_seq k=%0d got %h exp %h", k, dac_out0, exp_q[k][15:0]);
      else passCount++;
      step();
    end
    step();
    trig_in = 1'b1;
    step();
    trig_in = 1'b0;
    for (int k = 0; k < 6; k++) begin
      checkCount++;
      if (busy !== 1'b0 || dac_out0 !== 16'd0)
        $display("[TB] FAIL trig_disarmed k=%0d busy=%b out=%h exp 0/0", k, busy, dac_out0);
      else passCount++;
      step();
    end
  endtask
`endif

  initial begin
    bus_if.sys_addr  = '0;
    bus_if.sys_wdata = '0;
    bus_if.sys_wen   = 1'b0;
    bus_if.sys_ren   = 1'b0;
`ifdef DAC_PLAYBACK_EXT_TRIG_EN
    trig_in = 1'b0;
`endif
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    step();
    test_reset();
    test_bus();
    test_oneshot_basic();
    test_random_oneshot();
    test_loop_stop();
    test_back_to_back();
    test_loop_clear();
    test_start_stop_same();
    test_async_reset();
`ifdef DAC_PLAYBACK_EXT_TRIG_EN
    test_ext_trig();
`endif
    $display("[TB] %0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
